// File: rtl/uart_tx_frame_arbiter_pkg.sv
// Shared types and helpers for the round-robin UART TX frame arbiter.
package uart_tx_frame_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_frame_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    int cand;

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves a latch.
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        // Walk from the farthest offset down so the nearest requester wins last.
        for (int off = NUM_SRC - 1; off >= 0; off--) begin
            cand = int'(ptr) + off;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            if (req[cand]) begin
                grant_idx = IDX_W'(cand);
                grant_any = 1'b1;
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// Round-robin arbiter that latches one multi-byte frame per grant and streams it,
// LSB byte first, into the UART TX serializer over its VALID/Busy handshake.
module uart_tx_frame_arbiter
    import uart_tx_frame_arbiter_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter int  NUM_SRC   = 2,
    parameter int  MAX_BYTES = 2,
    localparam int CNT_W     = $clog2(MAX_BYTES + 1),
    localparam int SRC_W     = clog2_min1(NUM_SRC)
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [NUM_SRC-1:0]                 SRC_VALID,
    input  logic [NUM_SRC*MAX_BYTES*WIDTH-1:0] SRC_DATA,
    input  logic [NUM_SRC*CNT_W-1:0]           SRC_NBYTES,
    output logic [NUM_SRC-1:0]                 SRC_READY,
    input  logic                               UART_TX_Busy,
    output logic                               UART_TX_VALID,
    output logic [WIDTH-1:0]                   UART_TX_DATA,
    output logic                               ARB_BUSY,
    output logic [SRC_W-1:0]                   ARB_SRC
);

    localparam int FRAME_W = MAX_BYTES * WIDTH;

    state_t               state, state_nxt;
    logic [SRC_W-1:0]     rr_ptr;
    logic [NUM_SRC-1:0]   grant;
    logic [SRC_W-1:0]     grant_idx;
    logic                 grant_any;
    logic [FRAME_W-1:0]   sel_frame;
    logic [CNT_W-1:0]     sel_nbytes_raw;
    logic [CNT_W-1:0]     sel_nbytes;
    logic [FRAME_W-1:0]   frame;
    logic [CNT_W-1:0]     nbytes;
    logic [CNT_W-1:0]     byte_idx;
    logic [CNT_W:0]       idx_inc;
    logic                 more_bytes;
    logic [WIDTH-1:0]     next_byte;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (SRC_W)
    ) u_rr_arbiter (
        .req       (SRC_VALID),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign sel_frame      = SRC_DATA[int'(grant_idx)*FRAME_W +: FRAME_W];
    assign sel_nbytes_raw = SRC_NBYTES[int'(grant_idx)*CNT_W +: CNT_W];
    assign sel_nbytes     = (sel_nbytes_raw > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : sel_nbytes_raw;

    assign idx_inc    = {1'b0, byte_idx} + 1'b1;
    assign more_bytes = idx_inc < {1'b0, nbytes};
    assign next_byte  = frame[int'(idx_inc)*WIDTH +: WIDTH];

    // Reset is gated in so no source sees a handshake while the block is held in reset.
    assign SRC_READY = (state == IDLE && !RST) ? grant : '0;
    assign ARB_BUSY  = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_any && sel_nbytes != '0) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (UART_TX_Busy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!UART_TX_Busy) begin
                    state_nxt = more_bytes ? SEND : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: all clocked state uses non-blocking assignments so every register sees pre-edge values.
        if (RST) begin
            state         <= IDLE;
            UART_TX_VALID <= 1'b0;
            UART_TX_DATA  <= '0;
            byte_idx      <= '0;
            rr_ptr        <= '0;
            ARB_SRC       <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        ARB_SRC  <= grant_idx;
                        rr_ptr   <= (int'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + 1'b1;
                        byte_idx <= '0;
                        if (sel_nbytes != '0) begin
                            UART_TX_VALID <= 1'b1;
                            UART_TX_DATA  <= sel_frame[WIDTH-1:0];
                        end
                    end
                end
                SEND: begin
                    if (UART_TX_Busy) begin
                        UART_TX_VALID <= 1'b0;
                        UART_TX_DATA  <= '0;
                    end
                end
                WAIT_DONE: begin
                    if (!UART_TX_Busy && more_bytes) begin
                        byte_idx      <= byte_idx + 1'b1;
                        UART_TX_VALID <= 1'b1;
                        UART_TX_DATA  <= next_byte;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the payload registers carry no reset; they are only read after a fresh capture.
    always_ff @(posedge CLK) begin
        if (state == IDLE && grant_any) begin
            frame  <= sel_frame;
            nbytes <= sel_nbytes;
        end
    end

endmodule
